bp_lite_mem_arbiter: RTL and testbench

- Merges the two BedRock stream memory ports of the unicore-lite tile into one port toward the L2/memory adapter.
  - Port 0 is the I$ UCE; port 1 is the D$ UCE, already resynchronised to the positive edge.
- Commands are arbitrated per message: the grant is held from the first beat through the beat with `last`.
- The memory returns responses in order. An in-order tracking FIFO records which source issued each command, and response beats are steered back to that source.

---
 rtl/bp_lite_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_bp_lite_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_lite_mem_arbiter.sv
// rtl/bp_lite_mem_arbiter.sv - merges the I$/D$ BedRock stream memory ports and steers in-order responses back
// Define BP_LITE_MEM_ARB_DCACHE_PRIO_EN for fixed D$ priority; round robin otherwise.

package bp_lite_mem_arbiter_pkg;
    typedef enum logic [0:0] {
        e_bp_default_cfg,
        e_bp_half_fill_cfg
    } bp_params_e;

    function automatic int mem_header_width(bp_params_e cfg);
        return (cfg == e_bp_default_cfg) ? 32 : 24;
    endfunction

    function automatic int uce_fill_width(bp_params_e cfg);
        return (cfg == e_bp_default_cfg) ? 64 : 32;
    endfunction
endpackage

module bp_lite_mem_arbiter_fifo #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               push_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                do_push, do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wptr_r <= wptr_r + ptr_w_lp'(1);
            if (do_pop)  rptr_r <= rptr_r + ptr_w_lp'(1);
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_r[wptr_r] <= data_i;
    end

    assign data_o  = mem_r[rptr_r];
    assign full_o  = (count_r == cnt_w_lp'(els_p));
    assign empty_o = (count_r == '0);
endmodule

module bp_lite_mem_arbiter
    import bp_lite_mem_arbiter_pkg::*;
#(
    parameter bp_params_e bp_params_p       = e_bp_default_cfg,
    parameter int         data_width_p      = uce_fill_width(bp_params_p),
    parameter int         outstanding_els_p = 4,
    localparam int        mem_header_width_lp = mem_header_width(bp_params_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,

    input  logic [1:0][mem_header_width_lp-1:0] mem_cmd_header_i,
    input  logic [1:0][data_width_p-1:0]        mem_cmd_data_i,
    input  logic [1:0]                          mem_cmd_v_i,
    input  logic [1:0]                          mem_cmd_last_i,
    output logic [1:0]                          mem_cmd_ready_and_o,

    output logic [mem_header_width_lp-1:0]      mem_cmd_header_o,
    output logic [data_width_p-1:0]             mem_cmd_data_o,
    output logic                                mem_cmd_v_o,
    output logic                                mem_cmd_last_o,
    input  logic                                mem_cmd_ready_and_i,

    input  logic [mem_header_width_lp-1:0]      mem_resp_header_i,
    input  logic [data_width_p-1:0]             mem_resp_data_i,
    input  logic                                mem_resp_v_i,
    input  logic                                mem_resp_last_i,
    output logic                                mem_resp_ready_and_o,

    output logic [1:0][mem_header_width_lp-1:0] mem_resp_header_o,
    output logic [1:0][data_width_p-1:0]        mem_resp_data_o,
    output logic [1:0]                          mem_resp_v_o,
    output logic [1:0]                          mem_resp_last_o,
    input  logic [1:0]                          mem_resp_ready_and_i
);
    typedef enum logic {e_idle, e_locked} state_e;

    state_e state_r, state_n;
    logic   gnt_r, gnt_n;
    logic   mid_r;
    logic   sel, chosen, ok;
    logic   cmd_xfer, cmd_first, cmd_done;
    logic   resp_v, resp_pop;
    logic   fifo_full, fifo_empty, head;

`ifdef BP_LITE_MEM_ARB_DCACHE_PRIO_EN
    assign sel = mem_cmd_v_i[1];
`else
    logic last_win_r;

    assign sel = (&mem_cmd_v_i) ? ~last_win_r : mem_cmd_v_i[1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)    last_win_r <= 1'b1;
        else if (cmd_done) last_win_r <= chosen;
    end
`endif

    assign chosen = (state_r == e_locked) ? gnt_r : sel;

    assign mem_cmd_header_o = mem_cmd_header_i[chosen];
    assign mem_cmd_data_o   = mem_cmd_data_i[chosen];
    assign mem_cmd_last_o   = mem_cmd_last_i[chosen];
    assign mem_cmd_v_o      = reset_n_i & mem_cmd_v_i[chosen];

    // A grant can be locked before its first beat moves (stalled on full), so
    // the full check keys off "first beat already sent" rather than the state.
    assign ok = reset_n_i & mem_cmd_ready_and_i & (mid_r | ~fifo_full);
    assign mem_cmd_ready_and_o = {ok & chosen, ok & ~chosen};

    assign cmd_xfer  = mem_cmd_v_o & ok;
    assign cmd_first = cmd_xfer & ~mid_r;
    assign cmd_done  = cmd_xfer & mem_cmd_last_o;

    always_comb begin
        state_n = state_r;
        gnt_n   = gnt_r;
        case (state_r)
            e_idle: begin
                if (mem_cmd_v_o && !cmd_done) begin
                    state_n = e_locked;
                    gnt_n   = sel;
                end
            end
            e_locked: begin
                if (cmd_done) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            gnt_r   <= 1'b0;
            mid_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            gnt_r   <= gnt_n;
            if (cmd_xfer) mid_r <= ~mem_cmd_last_o;
        end
    end

    bp_lite_mem_arbiter_fifo #(
        .width_p (1),
        .els_p   (outstanding_els_p)
    ) tracker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (chosen),
        .push_i    (cmd_first),
        .pop_i     (resp_pop),
        .data_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign resp_v               = reset_n_i & mem_resp_v_i & ~fifo_empty;
    assign mem_resp_v_o         = {resp_v & head, resp_v & ~head};
    assign mem_resp_ready_and_o = reset_n_i & ~fifo_empty & mem_resp_ready_and_i[head];
    assign resp_pop             = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

    assign mem_resp_header_o = {2{mem_resp_header_i}};
    assign mem_resp_data_o   = {2{mem_resp_data_i}};
    assign mem_resp_last_o   = {2{mem_resp_last_i}};

    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(mem_resp_v_i && fifo_empty));
endmodule

// File: tb/tb_bp_lite_mem_arbiter.sv
// tb/tb_bp_lite_mem_arbiter.sv - scoreboard bench for bp_lite_mem_arbiter
// Define BP_LITE_MEM_ARB_DCACHE_PRIO_EN to check the fixed D$ priority build.

module tb_bp_lite_mem_arbiter;
    localparam int HW = 32;
    localparam int DW = 64;

    typedef struct {
        logic          src;
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0][HW-1:0]   cmd_hdr_i;
    logic [1:0][DW-1:0]   cmd_data_i;
    logic [1:0]           cmd_v_i, cmd_last_i, cmd_rdy_o;
    logic [HW-1:0]        cmd_hdr_o;
    logic [DW-1:0]        cmd_data_o;
    logic                 cmd_v_o, cmd_last_o, cmd_rdy_i;
    logic [HW-1:0]        resp_hdr_i;
    logic [DW-1:0]        resp_data_i;
    logic                 resp_v_i, resp_last_i, resp_rdy_o;
    logic [1:0][HW-1:0]   resp_hdr_o;
    logic [1:0][DW-1:0]   resp_data_o;
    logic [1:0]           resp_v_o, resp_last_o, resp_rdy_i;

    beat_t src0_q[$], src1_q[$], mem_q[$];
    beat_t exp_cmd_q[$], exp_resp_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;

    always #5 clk = ~clk;

    bp_lite_mem_arbiter dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .mem_cmd_header_i     (cmd_hdr_i),
        .mem_cmd_data_i       (cmd_data_i),
        .mem_cmd_v_i          (cmd_v_i),
        .mem_cmd_last_i       (cmd_last_i),
        .mem_cmd_ready_and_o  (cmd_rdy_o),
        .mem_cmd_header_o     (cmd_hdr_o),
        .mem_cmd_data_o       (cmd_data_o),
        .mem_cmd_v_o          (cmd_v_o),
        .mem_cmd_last_o       (cmd_last_o),
        .mem_cmd_ready_and_i  (cmd_rdy_i),
        .mem_resp_header_i    (resp_hdr_i),
        .mem_resp_data_i      (resp_data_i),
        .mem_resp_v_i         (resp_v_i),
        .mem_resp_last_i      (resp_last_i),
        .mem_resp_ready_and_o (resp_rdy_o),
        .mem_resp_header_o    (resp_hdr_o),
        .mem_resp_data_o      (resp_data_o),
        .mem_resp_v_o         (resp_v_o),
        .mem_resp_last_o      (resp_last_o),
        .mem_resp_ready_and_i (resp_rdy_i)
    );

    function automatic beat_t mk_cmd(logic src, int id, int beat, logic last);
        beat_t b;
        b.src  = src;
        b.hdr  = {8'hC0, 7'd0, src, 16'(id)};
        b.data = {16'hDA7A, 15'd0, src, 16'(id), 16'(beat)};
        b.last = last;
        return b;
    endfunction

    function automatic beat_t mk_resp(logic src, int id, logic last);
        beat_t b;
        b.src  = src;
        b.hdr  = {16'hBEEF, 16'(id)};
        b.data = {32'h0, 16'hBEEF, 16'(id)};
        b.last = last;
        return b;
    endfunction

    // One cycle of source and memory models; samples handshakes #1 after the negedge.
    task automatic tick(input logic [1:0] rsp_rdy, output logic xfer, output logic [1:0] crdy,
                        output logic [1:0] got);
        @(negedge clk);
        cmd_v_i = {src1_q.size() != 0, src0_q.size() != 0};
        if (src0_q.size() != 0) begin
            cmd_hdr_i[0] = src0_q[0].hdr; cmd_data_i[0] = src0_q[0].data; cmd_last_i[0] = src0_q[0].last;
        end
        if (src1_q.size() != 0) begin
            cmd_hdr_i[1] = src1_q[0].hdr; cmd_data_i[1] = src1_q[0].data; cmd_last_i[1] = src1_q[0].last;
        end
        resp_v_i = (mem_q.size() != 0);
        if (mem_q.size() != 0) begin
            resp_hdr_i = mem_q[0].hdr; resp_data_i = mem_q[0].data; resp_last_i = mem_q[0].last;
        end
        resp_rdy_i = rsp_rdy;
        #1;
        crdy = cmd_rdy_o;
        xfer = cmd_v_o & (|cmd_rdy_o);
        got  = resp_v_o & resp_rdy_i;
        if (cmd_v_i[0] && cmd_rdy_o[0]) void'(src0_q.pop_front());
        if (cmd_v_i[1] && cmd_rdy_o[1]) void'(src1_q.pop_front());
        if (resp_v_i && resp_rdy_o) void'(mem_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_v_i = 2'b00; cmd_last_i = 2'b00; cmd_rdy_i = 1'b1;
        resp_v_i = 1'b0; resp_last_i = 1'b0; resp_rdy_i = 2'b11;
        src0_q.delete(); src1_q.delete(); mem_q.delete();
        exp_cmd_q.delete(); exp_resp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cmd_hdr_i = '0; cmd_data_i = '0; resp_hdr_i = '0; resp_data_i = '0;
        cmd_v_i = 2'b11; cmd_last_i = 2'b11; cmd_rdy_i = 1'b1;
        resp_v_i = 1'b1; resp_last_i = 1'b1; resp_rdy_i = 2'b11;
        @(negedge clk); #1;
        total_cnt++;
        if (cmd_v_o !== 1'b0) $display("FAIL reset_cmd_v: got %b expected 0", cmd_v_o); else pass_cnt++;
        total_cnt++;
        if (cmd_rdy_o !== 2'b00) $display("FAIL reset_cmd_rdy: got %b expected 00", cmd_rdy_o); else pass_cnt++;
        total_cnt++;
        if (resp_v_o !== 2'b00) $display("FAIL reset_resp_v: got %b expected 00", resp_v_o); else pass_cnt++;
        total_cnt++;
        if (resp_rdy_o !== 1'b0) $display("FAIL reset_resp_rdy: got %b expected 0", resp_rdy_o); else pass_cnt++;
        resp_v_i = 1'b0; cmd_v_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (resp_rdy_o !== 1'b0) $display("FAIL reset_fifo_empty: got resp ready %b expected 0", resp_rdy_o);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic xfer; logic [1:0] crdy, got;
        logic [3:0] order;
        int idc[2];
        int n;
        beat_t e;
`ifdef BP_LITE_MEM_ARB_DCACHE_PRIO_EN
        order = 4'b1111;
`else
        order = 4'b1010;
`endif
        do_reset();
        idc[0] = 0; idc[1] = 0;
        for (int i = 0; i < 4; i++) begin
            src0_q.push_back(mk_cmd(1'b0, i, 0, 1'b1));
            src1_q.push_back(mk_cmd(1'b1, i, 0, 1'b1));
            exp_cmd_q.push_back(mk_cmd(order[i], idc[order[i]], 0, 1'b1));
            exp_resp_q.push_back(mk_resp(order[i], i, 1'b1));
            idc[order[i]]++;
        end
        n = 0;
        for (int c = 0; c < 10 && n < 4; c++) begin
            tick(2'b11, xfer, crdy, got);
            if (xfer) begin
                n++;
                total_cnt++;
                e = exp_cmd_q.pop_front();
                if (cmd_hdr_o !== e.hdr || cmd_data_o !== e.data || cmd_last_o !== e.last ||
                    crdy !== (e.src ? 2'b10 : 2'b01))
                    $display("FAIL rr_cmd: got rdy %b hdr %h last %b expected src %b hdr %h last %b",
                             crdy, cmd_hdr_o, cmd_last_o, e.src, e.hdr, e.last);
                else pass_cnt++;
            end
        end
        src0_q.delete(); src1_q.delete();
        total_cnt++;
        if (n !== 4) $display("FAIL rr_count: got %0d transfers expected 4", n); else pass_cnt++;
        for (int i = 0; i < 4; i++) mem_q.push_back(mk_resp(1'b0, i, 1'b1));
        n = 0;
        for (int c = 0; c < 10 && n < 4; c++) begin
            tick(2'b11, xfer, crdy, got);
            if (got != 2'b00) begin
                n++;
                total_cnt++;
                e = exp_resp_q.pop_front();
                if (got !== (e.src ? 2'b10 : 2'b01) || resp_hdr_o[e.src] !== e.hdr || resp_last_o[e.src] !== e.last)
                    $display("FAIL rr_resp: got v %b hdr %h expected src %b hdr %h",
                             got, resp_hdr_o[e.src], e.src, e.hdr);
                else pass_cnt++;
            end
        end
        tick(2'b11, xfer, crdy, got);
        total_cnt++;
        if (n !== 4 || resp_rdy_o !== 1'b0)
            $display("FAIL rr_drain: got %0d responses ready %b expected 4 and 0", n, resp_rdy_o);
        else pass_cnt++;
    endtask

    task automatic test_locked_burst();
        logic xfer; logic [1:0] crdy, got;
        int n, cycles;
        beat_t e;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            src0_q.push_back(mk_cmd(1'b0, 16, b, b == 3));
            exp_cmd_q.push_back(mk_cmd(1'b0, 16, b, b == 3));
        end
        exp_cmd_q.push_back(mk_cmd(1'b1, 32, 0, 1'b1));
        n = 0; cycles = 0;
        for (int c = 0; c < 12 && n < 5; c++) begin
            tick(2'b11, xfer, crdy, got);
            cycles++;
            if (cmd_v_i[1] && n < 4) begin
                total_cnt++;
                if (crdy[1] !== 1'b0) $display("FAIL burst_d_blocked: got D ready %b expected 0", crdy[1]);
                else pass_cnt++;
            end
            if (xfer) begin
                n++;
                total_cnt++;
                e = exp_cmd_q.pop_front();
                if (cmd_hdr_o !== e.hdr || cmd_data_o !== e.data || cmd_last_o !== e.last ||
                    crdy !== (e.src ? 2'b10 : 2'b01))
                    $display("FAIL burst_cmd: got rdy %b data %h last %b expected src %b data %h last %b",
                             crdy, cmd_data_o, cmd_last_o, e.src, e.data, e.last);
                else pass_cnt++;
                if (n == 1) src1_q.push_back(mk_cmd(1'b1, 32, 0, 1'b1));
            end
        end
        total_cnt++;
        if (cycles !== 5 || n !== 5) $display("FAIL burst_contiguous: got %0d beats in %0d cycles expected 5 in 5", n, cycles);
        else pass_cnt++;
    endtask

    task automatic test_full_stall();
        logic xfer; logic [1:0] crdy, got;
        beat_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            src0_q.push_back(mk_cmd(1'b0, i, 0, 1'b1));
            exp_cmd_q.push_back(mk_cmd(1'b0, i, 0, 1'b1));
        end
        for (int c = 0; c < 4; c++) begin
            tick(2'b11, xfer, crdy, got);
            total_cnt++;
            e = exp_cmd_q[0];
            if (!xfer || cmd_hdr_o !== e.hdr || crdy !== 2'b01)
                $display("FAIL full_b2b: got xfer %b hdr %h expected 1 hdr %h", xfer, cmd_hdr_o, e.hdr);
            else pass_cnt++;
            if (xfer) void'(exp_cmd_q.pop_front());
        end
        for (int c = 0; c < 2; c++) begin
            tick(2'b11, xfer, crdy, got);
            total_cnt++;
            if (crdy !== 2'b00 || xfer !== 1'b0) $display("FAIL full_stall: got ready %b expected 00", crdy);
            else pass_cnt++;
        end
        mem_q.push_back(mk_resp(1'b0, 0, 1'b1));
        tick(2'b11, xfer, crdy, got);
        total_cnt++;
        if (got !== 2'b01 || crdy !== 2'b00)
            $display("FAIL full_pop_cycle: got resp %b cmd ready %b expected 01 and 00", got, crdy);
        else pass_cnt++;
        tick(2'b11, xfer, crdy, got);
        total_cnt++;
        e = exp_cmd_q[0];
        if (!xfer || crdy !== 2'b01 || cmd_hdr_o !== e.hdr)
            $display("FAIL full_resume: got xfer %b ready %b hdr %h expected 1 01 %h", xfer, crdy, cmd_hdr_o, e.hdr);
        else pass_cnt++;
    endtask

    task automatic test_resp_steer();
        logic xfer; logic [1:0] crdy, got;
        int n;
        beat_t e;
        do_reset();
        src0_q.push_back(mk_cmd(1'b0, 48, 0, 1'b1));
        tick(2'b11, xfer, crdy, got);
        src1_q.push_back(mk_cmd(1'b1, 49, 0, 1'b1));
        tick(2'b11, xfer, crdy, got);
        total_cnt++;
        if (!xfer || crdy !== 2'b10) $display("FAIL steer_issue: got xfer %b ready %b expected 1 10", xfer, crdy);
        else pass_cnt++;
        mem_q.push_back(mk_resp(1'b0, 0, 1'b0));
        mem_q.push_back(mk_resp(1'b0, 1, 1'b1));
        mem_q.push_back(mk_resp(1'b1, 2, 1'b1));
        exp_resp_q.push_back(mk_resp(1'b0, 0, 1'b0));
        exp_resp_q.push_back(mk_resp(1'b0, 1, 1'b1));
        exp_resp_q.push_back(mk_resp(1'b1, 2, 1'b1));
        for (int c = 0; c < 2; c++) begin
            tick(2'b10, xfer, crdy, got);
            total_cnt++;
            if (resp_v_o !== 2'b01 || resp_rdy_o !== 1'b0 || got !== 2'b00)
                $display("FAIL steer_hold: got v %b ready %b expected 01 0", resp_v_o, resp_rdy_o);
            else pass_cnt++;
        end
        n = 0;
        for (int c = 0; c < 8 && n < 3; c++) begin
            tick(2'b11, xfer, crdy, got);
            if (got != 2'b00) begin
                n++;
                total_cnt++;
                e = exp_resp_q.pop_front();
                if (got !== (e.src ? 2'b10 : 2'b01) || resp_hdr_o[e.src] !== e.hdr ||
                    resp_data_o[e.src] !== e.data || resp_last_o[e.src] !== e.last)
                    $display("FAIL steer_resp: got v %b hdr %h last %b expected src %b hdr %h last %b",
                             got, resp_hdr_o[e.src], resp_last_o[e.src], e.src, e.hdr, e.last);
                else pass_cnt++;
            end
        end
        tick(2'b11, xfer, crdy, got);
        total_cnt++;
        if (n !== 3 || resp_rdy_o !== 1'b0)
            $display("FAIL steer_drain: got %0d beats ready %b expected 3 and 0", n, resp_rdy_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_locked();
        logic xfer; logic [1:0] crdy, got;
        beat_t e;
        do_reset();
        src0_q.push_back(mk_cmd(1'b0, 64, 0, 1'b1));
        tick(2'b11, xfer, crdy, got);
        for (int b = 0; b < 3; b++) src1_q.push_back(mk_cmd(1'b1, 65, b, b == 2));
        tick(2'b11, xfer, crdy, got);
        tick(2'b11, xfer, crdy, got);
        total_cnt++;
        if (!xfer || crdy !== 2'b10 || cmd_last_o !== 1'b0)
            $display("FAIL rl_lock: got xfer %b ready %b last %b expected 1 10 0", xfer, crdy, cmd_last_o);
        else pass_cnt++;
        @(negedge clk);
        cmd_v_i = 2'b10; cmd_hdr_i[1] = src1_q[0].hdr; cmd_last_i[1] = 1'b1;
        resp_rdy_i = 2'b11;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (cmd_v_o !== 1'b0 || resp_v_o !== 2'b00 || cmd_rdy_o !== 2'b00 || resp_rdy_o !== 1'b0)
            $display("FAIL rl_outputs: got cmd v %b resp v %b cmd rdy %b resp rdy %b expected all 0",
                     cmd_v_o, resp_v_o, cmd_rdy_o, resp_rdy_o);
        else pass_cnt++;
        src0_q.delete(); src1_q.delete();
        cmd_v_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (resp_rdy_o !== 1'b0) $display("FAIL rl_fifo_empty: got resp ready %b expected 0", resp_rdy_o);
        else pass_cnt++;
        src0_q.push_back(mk_cmd(1'b0, 66, 0, 1'b1));
        e = mk_cmd(1'b0, 66, 0, 1'b1);
        tick(2'b11, xfer, crdy, got);
        total_cnt++;
        if (!xfer || crdy !== 2'b01 || cmd_hdr_o !== e.hdr)
            $display("FAIL rl_idle: got xfer %b ready %b hdr %h expected 1 01 %h", xfer, crdy, cmd_hdr_o, e.hdr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_locked_burst();
        test_full_stall();
        test_resp_steer();
        test_reset_locked();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
